// File: rtl/sha3_scan_pkg.sv
// Shared types and constants for the SHA3 scan result path: result kinds,
// the default-width result entry layout and the reserved-slot admission limit.
package sha3_scan_pkg;

   typedef enum logic [1:0] {
      NONE       = 2'b00,
      FOUND      = 2'b01,
      LAST       = 2'b10,
      FOUND_LAST = 2'b11
   } result_kind_t;

   localparam int ENTRY_NONCE_W = 32;
   localparam int ENTRY_HASH_W  = 64;

   typedef struct packed {
      result_kind_t              kind;
      logic [ENTRY_NONCE_W-1:0]  nonce;
      logic [ENTRY_HASH_W-1:0]   hash;
   } result_entry_t;

   // The final FIFO slot is kept free for end-of-scan markers.
   localparam int RESERVE_SLOTS = 1;

   function automatic int found_limit(input int depth);
      return depth - RESERVE_SLOTS;
   endfunction

endpackage

// File: rtl/sha3_result_fifo.sv
// Synchronous FIFO with a registered head entry, exported occupancy and
// same-cycle push/pop. A push into an empty FIFO is visible at the same edge.
module sha3_result_fifo #(
   parameter  int W     = 98,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic          head_valid,
   output logic [W-1:0]  head_data,
   output logic [CW-1:0] cnt
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] TWO  = CW'(2);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] next_rd;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && head_valid;
   assign do_push = push && (cnt != FULL);
   assign next_rd = rd_ptr + 1'b1;

   // Every push lands in storage, even when it is also loaded straight into
   // the head register, so the entry behind the head is always in mem.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= next_rd;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (do_pop) begin
            if (cnt >= TWO) begin
               head_data <= mem[next_rd];
            end else if (do_push) begin
               head_data <= push_data;
            end else begin
               head_valid <= 1'b0;
            end
         end else if (!head_valid && do_push) begin
            head_data  <= push_data;
            head_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha3_scan_result_collector.sv
// Filters scanner result beats down to winners and end-of-scan markers,
// queues them for the host link and keeps saturating scan statistics.
module sha3_scan_result_collector
   import sha3_scan_pkg::*;
#(
   parameter int NONCE_W = 32,
   parameter int HASH_W  = 64,
   parameter int DEPTH   = 8,
   parameter int STAT_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               res_valid,
   input  logic               res_found,
   input  logic               res_last,
   input  logic [NONCE_W-1:0] res_nonce,
   input  logic [HASH_W-1:0]  res_hash,
   output logic               out_valid,
   input  logic               out_ready,
   output result_kind_t       out_kind,
   output logic [NONCE_W-1:0] out_nonce,
   output logic [HASH_W-1:0]  out_hash,
   output logic [STAT_W-1:0]  stat_evaluated,
   output logic [STAT_W-1:0]  stat_found,
   output logic [STAT_W-1:0]  stat_dropped,
   output logic               overflow
);

   localparam int              CW          = $clog2(DEPTH) + 1;
   localparam int              EW          = 2 + NONCE_W + HASH_W;
   localparam logic [CW-1:0]   FULL        = CW'(DEPTH);
   localparam logic [CW-1:0]   FOUND_LIMIT = CW'(found_limit(DEPTH));
   localparam logic [STAT_W-1:0] STAT_MAX  = '1;

   typedef struct packed {
      result_kind_t        kind;
      logic [NONCE_W-1:0]  nonce;
      logic [HASH_W-1:0]   hash;
   } entry_t;

   entry_t        push_entry;
   entry_t        head_entry;
   logic [CW-1:0] cnt;
   logic          candidate;
   logic          room;
   logic          accept;
   logic          drop_found;
   logic          lose_last;
   logic          pop;
   logic          head_valid;

   // Admission uses the pre-pop occupancy; a same-cycle pop never frees room.
   always_comb begin
      candidate        = res_valid && (res_found || res_last);
      room             = res_last ? (cnt < FULL) : (cnt < FOUND_LIMIT);
      accept           = candidate && room;
      drop_found       = res_valid && res_found && !room;
      lose_last        = res_valid && res_last && !room;
      push_entry.kind  = result_kind_t'({res_last, res_found});
      push_entry.nonce = res_nonce;
      push_entry.hash  = res_hash;
   end

   assign pop = head_valid && out_ready;

   sha3_result_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept),
      .push_data  (push_entry),
      .pop        (pop),
      .head_valid (head_valid),
      .head_data  (head_entry),
      .cnt        (cnt)
   );

   assign out_valid = head_valid;
   assign out_kind  = head_entry.kind;
   assign out_nonce = head_entry.nonce;
   assign out_hash  = head_entry.hash;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_evaluated <= '0;
         stat_found     <= '0;
         stat_dropped   <= '0;
         overflow       <= 1'b0;
      end else begin
         if (res_valid && stat_evaluated != STAT_MAX) begin
            stat_evaluated <= stat_evaluated + 1'b1;
         end
         if (accept && res_found && stat_found != STAT_MAX) begin
            stat_found <= stat_found + 1'b1;
         end
         if (drop_found && stat_dropped != STAT_MAX) begin
            stat_dropped <= stat_dropped + 1'b1;
         end
         if (lose_last) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sha3_scan_result_collector.sv
// Self-checking bench for sha3_scan_result_collector: directed scenarios plus
// random traffic compared each cycle against a queue-based reference model.
module tb_sha3_scan_result_collector;
   import sha3_scan_pkg::*;

   localparam int NONCE_W = 32;
   localparam int HASH_W  = 64;
   localparam int DEPTH   = 8;
   localparam int STAT_W  = 8;
   localparam int STAT_MAX = (1 << STAT_W) - 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               res_valid = 1'b0;
   logic               res_found = 1'b0;
   logic               res_last = 1'b0;
   logic [NONCE_W-1:0] res_nonce = '0;
   logic [HASH_W-1:0]  res_hash = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   result_kind_t       out_kind;
   logic [NONCE_W-1:0] out_nonce;
   logic [HASH_W-1:0]  out_hash;
   logic [STAT_W-1:0]  stat_evaluated;
   logic [STAT_W-1:0]  stat_found;
   logic [STAT_W-1:0]  stat_dropped;
   logic               overflow;

   sha3_scan_result_collector #(
      .NONCE_W (NONCE_W),
      .HASH_W  (HASH_W),
      .DEPTH   (DEPTH),
      .STAT_W  (STAT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .res_valid      (res_valid),
      .res_found      (res_found),
      .res_last       (res_last),
      .res_nonce      (res_nonce),
      .res_hash       (res_hash),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_kind       (out_kind),
      .out_nonce      (out_nonce),
      .out_hash       (out_hash),
      .stat_evaluated (stat_evaluated),
      .stat_found     (stat_found),
      .stat_dropped   (stat_dropped),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]         kind;
      logic [NONCE_W-1:0] nonce;
      logic [HASH_W-1:0]  hash;
   } model_entry_t;

   model_entry_t model_q[$];
   int           model_eval;
   int           model_found;
   int           model_dropped;
   bit           model_overflow;
   int           vectors;
   int           miscompares;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      check("out_valid", out_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
         check("out_kind", out_kind, model_q[0].kind);
         check("out_nonce", out_nonce, model_q[0].nonce);
         check("out_hash", out_hash, model_q[0].hash);
      end
      check("stat_evaluated", stat_evaluated, model_eval);
      check("stat_found", stat_found, model_found);
      check("stat_dropped", stat_dropped, model_dropped);
      check("overflow", overflow, model_overflow);
   endtask

   // One clock of stimulus; the model advances with the same inputs the DUT saw at the edge.
   task automatic applyStimulus(input bit rst, input bit v, input bit f, input bit l,
                                input logic [NONCE_W-1:0] n, input logic [HASH_W-1:0] h,
                                input bit rdy);
      int           occ;
      int           cap;
      bit           pop_now;
      bit           push_now;
      model_entry_t e;
      rst_n     = !rst;
      res_valid = v;
      res_found = f;
      res_last  = l;
      res_nonce = n;
      res_hash  = h;
      out_ready = rdy;
      @(posedge clk);
      if (rst) begin
         model_q.delete();
         model_eval     = 0;
         model_found    = 0;
         model_dropped  = 0;
         model_overflow = 0;
      end else begin
         occ      = model_q.size();
         pop_now  = (occ > 0) && rdy;
         push_now = 0;
         if (v) begin
            if (model_eval < STAT_MAX) model_eval++;
            if (f || l) begin
               cap = l ? DEPTH : DEPTH - 1;
               if (occ < cap) begin
                  push_now = 1;
                  if (f && model_found < STAT_MAX) model_found++;
               end else begin
                  if (f && model_dropped < STAT_MAX) model_dropped++;
                  if (l) model_overflow = 1;
               end
            end
         end
         if (pop_now) void'(model_q.pop_front());
         if (push_now) begin
            e.kind  = {l, f};
            e.nonce = n;
            e.hash  = h;
            model_q.push_back(e);
         end
      end
      #1;
      checkOutput();
   endtask

   task automatic idle(input int cycles, input bit rdy);
      for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, '0, '0, rdy);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      applyStimulus(1, 0, 0, 0, '0, '0, 1);
      applyStimulus(1, 0, 0, 0, '0, '0, 1);
      check("reset_out_nonce", out_nonce, 0);
      check("reset_out_kind", out_kind, 0);

      $display("[TB] scan of 100 nonces with two winners");
      for (int i = 0; i < 100; i++) begin
         applyStimulus(0, 1, (i == 17) || (i == 42), i == 99, NONCE_W'(i),
                       {$urandom(), $urandom()}, 1);
      end
      idle(3, 1);
      check("t1_evaluated", stat_evaluated, 100);
      check("t1_found", stat_found, 2);
      check("t1_dropped", stat_dropped, 0);

      $display("[TB] fill with winners while stalled");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, 1, 0, NONCE_W'(i), {$urandom(), $urandom()}, 0);
      end
      check("t2_dropped", stat_dropped, 3);
      applyStimulus(0, 1, 0, 1, 32'd10, {$urandom(), $urandom()}, 0);
      check("t2_overflow", overflow, 0);

      $display("[TB] marker lost on full queue, then drain");
      applyStimulus(0, 1, 0, 1, 32'd11, {$urandom(), $urandom()}, 0);
      check("t3_overflow", overflow, 1);
      check("t3_head_nonce", out_nonce, 0);
      idle(10, 1);

      $display("[TB] full queue with simultaneous pop and winner");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 1, 1, 0, NONCE_W'(100 + i), {$urandom(), $urandom()}, 0);
      end
      applyStimulus(0, 1, 0, 1, 32'd107, {$urandom(), $urandom()}, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 0, NONCE_W'(108 + i), {$urandom(), $urandom()}, 1);
      end
      idle(10, 1);

      $display("[TB] single found+last beat held under stall");
      applyStimulus(0, 1, 1, 1, 32'hDEADBEEF, 64'h0123456789ABCDEF, 0);
      check("t5_kind", out_kind, 2'b11);
      idle(5, 0);
      check("t5_hash", out_hash, 64'h0123456789ABCDEF);
      idle(2, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                       $urandom_range(0, 9) == 0, $urandom(), {$urandom(), $urandom()},
                       $urandom_range(0, 1) == 1);
      end
      idle(12, 1);

      $display("[TB] counter saturation and mid-burst reset");
      for (int i = 0; i < STAT_MAX + 5; i++) begin
         applyStimulus(0, 1, 0, 0, $urandom(), {$urandom(), $urandom()}, 1);
      end
      check("t6_saturated", stat_evaluated, STAT_MAX);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 0, NONCE_W'(200 + i), {$urandom(), $urandom()}, 0);
      end
      applyStimulus(1, 1, 1, 1, 32'd203, {$urandom(), $urandom()}, 0);
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_evaluated", stat_evaluated, 0);
      check("t6_rst_found", stat_found, 0);
      check("t6_rst_dropped", stat_dropped, 0);
      check("t6_rst_overflow", overflow, 0);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 9) == 0, $urandom(), {$urandom(), $urandom()},
                       $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
